// File: rtl/pkt_rx_reader.sv
// rtl/pkt_rx_reader.sv - MAC RX packet-interface reader with framing checks, skid FIFO and statistics
//
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   pkt_rx_avail              : MAC holds at least one complete frame
//   pkt_rx_ren                : read request to the MAC (data returns one cycle later)
//   pkt_rx_val/sop/eop/mod/data/err : MAC receive word
//   out_val/out_ready         : downstream valid/ready handshake
//   out_sop/eop/mod/data/err  : downstream word (FIFO head)
//   frame_cnt, err_cnt, framing_err_cnt : saturating statistics
//   last_len                  : byte length of the most recently completed frame
module pkt_rx_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic [2:0]       pkt_rx_mod,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_err,
    output logic             out_val,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [2:0]       out_mod,
    output logic [63:0]      out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] framing_err_cnt,
    output logic [13:0]      last_len
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = 70;  // {sop, eop, mod[2:0], data[63:0], err}

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic               in_frame_q, in_frame_d;
    logic [11:0]        words_q, words_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   ferr_cnt_q, ferr_cnt_d;
    logic [13:0]        last_len_q, last_len_d;
    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [WW-1:0]      mem_q [FIFO_DEPTH];

    logic [AW:0]        count_w;
    logic               empty_w, full_w;
    logic               push_w, pop_w, eop_push_w;
    logic               stray_w, resync_w;
    logic [WW-1:0]      push_word_w, head_w;
    logic [11:0]        prior_w;
    logic [3:0]         bytes_w;
    logic [15:0]        len_w;

    assign count_w = wr_ptr_q - rd_ptr_q;
    assign empty_w = (count_w == '0);
    assign full_w  = (count_w == (AW+1)'(FIFO_DEPTH));

    // Two free entries are needed: one for the word already in flight from
    // last cycle's request and one for the word this request returns.
    assign pkt_rx_ren = (state_q == READ) & ~(pkt_rx_val & pkt_rx_eop)
                      & (count_w <= (AW+1)'(FIFO_DEPTH - 2));

    // Continuation word with no open frame is dropped; SOP inside an open
    // frame restarts the frame and is flagged.
    assign stray_w    = pkt_rx_val & ~pkt_rx_sop & ~in_frame_q;
    assign resync_w   = pkt_rx_val &  pkt_rx_sop &  in_frame_q;
    assign push_w     = pkt_rx_val & (pkt_rx_sop | in_frame_q);
    assign eop_push_w = push_w & pkt_rx_eop;
    assign pop_w      = ~empty_w & out_ready;

    assign push_word_w = {pkt_rx_sop, pkt_rx_eop,
                          (pkt_rx_eop ? pkt_rx_mod : 3'd0),
                          pkt_rx_data,
                          ((pkt_rx_eop & pkt_rx_err) | resync_w)};

    // Words already accumulated before this one; an SOP restarts the count.
    assign prior_w = pkt_rx_sop ? 12'd0 : words_q;
    assign bytes_w = (pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, pkt_rx_mod};
    assign len_w   = {1'b0, prior_w, 3'b000} + {12'd0, bytes_w};

    assign head_w = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign out_val  = ~empty_w;
    assign out_sop  = head_w[69];
    assign out_eop  = head_w[68];
    assign out_mod  = head_w[67:65];
    assign out_data = head_w[64:1];
    assign out_err  = head_w[0];

    assign frame_cnt       = frame_cnt_q;
    assign err_cnt         = err_cnt_q;
    assign framing_err_cnt = ferr_cnt_q;
    assign last_len        = last_len_q;

    always_comb begin
        state_d     = state_q;
        in_frame_d  = in_frame_q;
        words_d     = words_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        ferr_cnt_d  = ferr_cnt_q;
        last_len_d  = last_len_q;

        case (state_q)
            IDLE:    if (pkt_rx_avail) state_d = READ;
            READ:    if (pkt_rx_val && pkt_rx_eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((stray_w || resync_w) && ferr_cnt_q != '1)
            ferr_cnt_d = ferr_cnt_q + CNT_W'(1);

        if (push_w) begin
            in_frame_d = ~pkt_rx_eop;
            words_d    = (prior_w == 12'hFFF) ? prior_w : prior_w + 12'd1;
        end

        if (eop_push_w) begin
            if (frame_cnt_q != '1)
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (pkt_rx_err && err_cnt_q != '1)
                err_cnt_d = err_cnt_q + CNT_W'(1);
            last_len_d = (len_w > 16'h3FFF) ? 14'h3FFF : len_w[13:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_frame_q  <= 1'b0;
            words_q     <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ferr_cnt_q  <= '0;
            last_len_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_frame_q  <= in_frame_d;
            words_q     <= words_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ferr_cnt_q  <= ferr_cnt_d;
            last_len_q  <= last_len_d;
            if (push_w) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= push_word_w;
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
                                  !(push_w && full_w && !pop_w));

endmodule

// File: tb/tb_pkt_rx_reader.sv
// tb/tb_pkt_rx_reader.sv - self-checking bench for pkt_rx_reader
module tb_pkt_rx_reader;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic [63:0] data;
        logic        err;
    } word_t;

    typedef struct {
        int         nwords;
        logic [2:0] mod;
        logic       err;
        int         rdy_mode;
        int         exp_len;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pkt_rx_avail = 1'b0;
    logic          pkt_rx_ren;
    logic          pkt_rx_val = 1'b0;
    logic          pkt_rx_sop = 1'b0;
    logic          pkt_rx_eop = 1'b0;
    logic [2:0]    pkt_rx_mod = 3'd0;
    logic [63:0]   pkt_rx_data = 64'd0;
    logic          pkt_rx_err = 1'b0;
    logic          out_val;
    logic          out_ready = 1'b1;
    logic          out_sop, out_eop, out_err;
    logic [2:0]    out_mod;
    logic [63:0]   out_data;
    logic [CW-1:0] frame_cnt, err_cnt, framing_err_cnt;
    logic [13:0]   last_len;

    pkt_rx_reader #(.FIFO_DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pkt_rx_avail(pkt_rx_avail), .pkt_rx_ren(pkt_rx_ren),
        .pkt_rx_val(pkt_rx_val), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
        .pkt_rx_mod(pkt_rx_mod), .pkt_rx_data(pkt_rx_data), .pkt_rx_err(pkt_rx_err),
        .out_val(out_val), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_mod(out_mod), .out_data(out_data), .out_err(out_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .framing_err_cnt(framing_err_cnt),
        .last_len(last_len)
    );

    always #5 clk = ~clk;

    word_t mac_q[$];
    word_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    ren_cnt = 0;
    bit    ren_pend = 0;
    bit    inj_pend = 0;
    word_t inj_w;
    int    ready_mode = 0;
    bit    stall_prev = 0;
    word_t held;

    bit m_in_frame;
    int m_words, m_frames, m_errs, m_ferrs;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Reference framing model: decides what the stream must show for each MAC word.
    task automatic model_word(input word_t w);
        word_t e;
        if (w.sop == m_in_frame) m_ferrs = sat_inc(m_ferrs);
        if (w.sop || m_in_frame) begin
            e     = w;
            e.mod = w.eop ? w.mod : 3'd0;
            e.err = (w.eop && w.err) || (w.sop && m_in_frame);
            sb.push_back(e);
            m_words = w.sop ? 1 : m_words + 1;
            if (w.eop) begin
                m_frames = sat_inc(m_frames);
                if (w.err) m_errs = sat_inc(m_errs);
                m_in_frame = 0;
            end else begin
                m_in_frame = 1;
            end
        end
    endtask

    task automatic drive(input word_t w);
        pkt_rx_val  = 1'b1;
        pkt_rx_sop  = w.sop;
        pkt_rx_eop  = w.eop;
        pkt_rx_mod  = w.mod;
        pkt_rx_data = w.data;
        pkt_rx_err  = w.err;
        model_word(w);
    endtask

    // MAC model: answers each sampled ren with the next queued word one cycle later.
    initial forever begin
        @(posedge clk);
        #1;
        pkt_rx_val = 1'b0;
        if (!reset) begin
            if (inj_pend) begin
                drive(inj_w);
                inj_pend = 0;
            end else if (ren_pend) begin
                check("mac_has_word", 96'(mac_q.size() != 0), 96'(1));
                if (mac_q.size() != 0) drive(mac_q.pop_front());
            end
        end
        pkt_rx_avail = !reset && (mac_q.size() != 0);
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    initial forever begin
        word_t cur;
        @(negedge clk);
        ren_pend = pkt_rx_ren;
        if (pkt_rx_ren) ren_cnt++;
        cur = {out_sop, out_eop, out_mod, out_data, out_err};
        if (out_val && stall_prev) check("stall_hold", 96'(cur), 96'(held));
        if (out_val && out_ready) begin
            check("out_expected", 96'(sb.size() != 0), 96'(1));
            if (sb.size() != 0) check("out_word", 96'(cur), 96'(sb.pop_front()));
        end
        stall_prev = out_val && !out_ready;
        held = cur;
    end

    task automatic do_reset();
        reset = 1'b1;
        mac_q.delete();
        sb.delete();
        inj_pend = 0;
        m_in_frame = 0;
        m_words = 0; m_frames = 0; m_errs = 0; m_ferrs = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (mac_q.size() == 0 && sb.size() == 0 && !pkt_rx_val && !inj_pend) begin
                done = 1;
                break;
            end
        end
        check({"drain_", name}, 96'(done), 96'(1));
    endtask

    task automatic push_word(input logic sop, input logic eop, input logic [2:0] mod, input logic err);
        word_t w;
        w.sop  = sop;
        w.eop  = eop;
        w.mod  = eop ? mod : 3'($urandom_range(0, 7));
        w.data = {$urandom, $urandom};
        w.err  = eop ? err : 1'($urandom_range(0, 1));
        mac_q.push_back(w);
    endtask

    task automatic load_frame(input int n, input logic [2:0] mod, input logic err);
        for (int i = 0; i < n; i++) push_word(i == 0, i == n - 1, mod, err);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, 96'(frame_cnt), 96'(m_frames));
        check({tag, "_err_cnt"}, 96'(err_cnt), 96'(m_errs));
        check({tag, "_ferr_cnt"}, 96'(framing_err_cnt), 96'(m_ferrs));
    endtask

    vec_t vecs[5];

    initial begin
        logic [63:0] w2data;
        bit          found;

        vecs[0] = '{nwords: 3,  mod: 3'd5, err: 1'b0, rdy_mode: 0, exp_len: 21};
        vecs[1] = '{nwords: 1,  mod: 3'd0, err: 1'b1, rdy_mode: 0, exp_len: 8};
        vecs[2] = '{nwords: 2,  mod: 3'd7, err: 1'b0, rdy_mode: 1, exp_len: 15};
        vecs[3] = '{nwords: 4,  mod: 3'd0, err: 1'b0, rdy_mode: 1, exp_len: 32};
        vecs[4] = '{nwords: 6,  mod: 3'd1, err: 1'b1, rdy_mode: 1, exp_len: 41};

        @(negedge clk);
        check("reset_outputs",
              96'({out_val, out_sop, out_eop, out_mod, out_data, out_err, pkt_rx_ren,
                   frame_cnt, err_cnt, framing_err_cnt, last_len}), 96'(0));
        do_reset();

        for (int i = 0; i < 5; i++) begin
            ready_mode = vecs[i].rdy_mode;
            ren_cnt = 0;
            load_frame(vecs[i].nwords, vecs[i].mod, vecs[i].err);
            wait_drain("table");
            check("table_ren_cycles", 96'(ren_cnt), 96'(vecs[i].nwords));
            check("table_last_len", 96'(last_len), 96'(vecs[i].exp_len));
            check_counters("table");
        end

        // Backpressure: 4 requests fill the FIFO, then nothing more until drained.
        ready_mode = 2;
        ren_cnt = 0;
        load_frame(10, 3'd0, 1'b0);
        repeat (14) @(negedge clk);
        check("bp_ren_stalled", 96'(ren_cnt), 96'(4));
        check("bp_out_val", 96'(out_val), 96'(1));
        check("bp_remaining", 96'(mac_q.size()), 96'(6));
        ready_mode = 0;
        wait_drain("bp");
        check("bp_ren_total", 96'(ren_cnt), 96'(10));
        check("bp_last_len", 96'(last_len), 96'(80));

        // Framing errors: stray word while idle, then an SOP inside an open frame.
        do_reset();
        inj_w = '{sop: 1'b0, eop: 1'b0, mod: 3'd0, data: 64'hDEAD_BEEF_0000_0001, err: 1'b0};
        inj_pend = 1;
        wait_drain("stray");
        check("stray_ferr", 96'(framing_err_cnt), 96'(1));
        check("stray_no_out", 96'(out_val), 96'(0));
        push_word(1'b1, 1'b0, 3'd0, 1'b0);
        push_word(1'b0, 1'b0, 3'd0, 1'b0);
        push_word(1'b1, 1'b0, 3'd0, 1'b0);
        push_word(1'b0, 1'b0, 3'd0, 1'b0);
        push_word(1'b0, 1'b1, 3'd2, 1'b0);
        wait_drain("resync");
        check("resync_ferr", 96'(framing_err_cnt), 96'(2));
        check("resync_last_len", 96'(last_len), 96'(18));
        check("resync_frame_cnt", 96'(frame_cnt), 96'(1));
        check_counters("resync");

        // Asynchronous reset in the middle of a 4-word frame.
        load_frame(4, 3'd3, 1'b0);
        w2data = mac_q[1].data;
        found = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (pkt_rx_val && pkt_rx_data == w2data) begin
                found = 1;
                break;
            end
        end
        check("midrst_word2_seen", 96'(found), 96'(1));
        reset = 1'b1;
        #1;
        check("midrst_outputs",
              96'({out_val, out_sop, out_eop, out_mod, out_data, out_err, pkt_rx_ren,
                   frame_cnt, err_cnt, framing_err_cnt, last_len}), 96'(0));
        do_reset();
        ren_cnt = 0;
        load_frame(4, 3'd3, 1'b0);
        wait_drain("postrst");
        check("postrst_last_len", 96'(last_len), 96'(27));
        check("postrst_frame_cnt", 96'(frame_cnt), 96'(1));
        check("postrst_ren", 96'(ren_cnt), 96'(4));

        // Counter saturation at CNT_W=2.
        do_reset();
        for (int i = 0; i < 5; i++) load_frame(1, 3'd0, 1'b1);
        wait_drain("sat");
        check("sat_frame_cnt", 96'(frame_cnt), 96'(3));
        check("sat_err_cnt", 96'(err_cnt), 96'(3));
        check("sat_last_len", 96'(last_len), 96'(8));
        check_counters("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
